// File: rtl/datapath_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer_if
// Description : Control/status bundle between the sequencer and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface datapath_sequencer_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [3:0]  Control_Signals;
    logic        MD_Read;
    logic        IncPC;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [3:0]  state_dbg;

    // master = sequencer, slave = datapath side
    modport master (
        input  run, ir, mem_ready,
        output enable, busSelect, Control_Signals, MD_Read, IncPC,
               busy, halted, fault, state_dbg
    );

    modport slave (
        output run, ir, mem_ready,
        input  enable, busSelect, Control_Signals, MD_Read, IncPC,
               busy, halted, fault, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer
// Description : Hardwired fetch/execute control unit for the Phase 2 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer #(
    parameter logic [4:0] OP_ADD  = 5'b00011,
    parameter logic [4:0] OP_SUB  = 5'b00100,
    parameter logic [4:0] OP_AND  = 5'b00101,
    parameter logic [4:0] OP_OR   = 5'b00110,
    parameter logic [4:0] OP_MUL  = 5'b01111,
    parameter logic [4:0] OP_DIV  = 5'b10000,
    parameter logic [4:0] OP_HALT = 5'b11011,
    parameter logic [3:0] ALU_ADD = 4'd3,
    parameter logic [3:0] ALU_SUB = 4'd4,
    parameter logic [3:0] ALU_AND = 4'd5,
    parameter logic [3:0] ALU_OR  = 4'd6,
    parameter logic [3:0] ALU_MUL = 4'd12,
    parameter logic [3:0] ALU_DIV = 4'd13
) (
    input  wire logic             clk,
    input  wire logic             clr,
    datapath_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8,
        S_FAULT = 4'd9
    } state_t;

    state_t     state_q, state_d;

    logic [4:0] w_op;
    logic [3:0] w_ra, w_rb, w_rc;
    logic       w_is_alu, w_is_md, w_is_halt;
    logic [3:0] w_alu_code;
    logic       w_unused_ir;

    assign w_op        = bus.ir[31:27];
    assign w_ra        = bus.ir[26:23];
    assign w_rb        = bus.ir[22:19];
    assign w_rc        = bus.ir[18:15];
    assign w_unused_ir = ^bus.ir[14:0];

    always_comb begin
        w_is_alu   = 1'b0;
        w_is_md    = 1'b0;
        w_is_halt  = 1'b0;
        w_alu_code = 4'd0;
        case (w_op)
            OP_ADD:  begin w_is_alu = 1'b1; w_alu_code = ALU_ADD; end
            OP_SUB:  begin w_is_alu = 1'b1; w_alu_code = ALU_SUB; end
            OP_AND:  begin w_is_alu = 1'b1; w_alu_code = ALU_AND; end
            OP_OR:   begin w_is_alu = 1'b1; w_alu_code = ALU_OR;  end
            OP_MUL:  begin w_is_md  = 1'b1; w_alu_code = ALU_MUL; end
            OP_DIV:  begin w_is_md  = 1'b1; w_alu_code = ALU_DIV; end
            OP_HALT: w_is_halt = 1'b1;
            default: ;
        endcase
    end

    // run is only looked at in IDLE and on the last step of an instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.run) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (bus.mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                if (w_is_halt)                 state_d = S_HALT;
                else if (w_is_alu || w_is_md)  state_d = S_T4;
                else                           state_d = S_FAULT;
            end
            S_T4:    state_d = S_T5;
            S_T5: begin
                if (w_is_md)      state_d = S_T6;
                else if (bus.run) state_d = S_T0;
                else              state_d = S_IDLE;
            end
            S_T6:    state_d = bus.run ? S_T0 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Moore decode; the async clear of state_q forces every output low at once
    always_comb begin
        bus.enable          = 32'd0;
        bus.busSelect       = 32'd0;
        bus.Control_Signals = 4'd0;
        bus.MD_Read         = 1'b0;
        bus.IncPC           = 1'b0;
        case (state_q)
            S_T0: begin
                bus.busSelect[20] = 1'b1;
                bus.enable[25]    = 1'b1;
                bus.enable[20]    = 1'b1;
                bus.IncPC         = 1'b1;
            end
            S_T1: begin
                bus.MD_Read    = 1'b1;
                bus.enable[21] = 1'b1;
            end
            S_T2: begin
                bus.busSelect[21] = 1'b1;
                bus.enable[24]    = 1'b1;
            end
            S_T3: begin
                if (w_is_alu) begin
                    bus.busSelect = 32'd1 << w_rb;
                    bus.enable[19] = 1'b1;
                end else if (w_is_md) begin
                    bus.busSelect = 32'd1 << w_ra;
                    bus.enable[19] = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_alu || w_is_md) begin
                    bus.busSelect       = 32'd1 << (w_is_md ? w_rb : w_rc);
                    bus.enable[18]      = 1'b1;
                    bus.Control_Signals = w_alu_code;
                end
            end
            S_T5: begin
                bus.busSelect[19] = 1'b1;
                if (w_is_md) bus.enable[17] = 1'b1;
                else         bus.enable     = 32'd1 << w_ra;
            end
            S_T6: begin
                bus.busSelect[18] = 1'b1;
                bus.enable[16]    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy      = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_FAULT);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.fault     = (state_q == S_FAULT);
    assign bus.state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_sequencer
// Description : Self-checking bench: directed vector table plus random programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    datapath_sequencer_if dif();

    datapath_sequencer u_dut (
        .clk (clk),
        .clr (clr),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one record = inputs driven this cycle + outputs expected this cycle
    typedef struct {
        logic [31:0] ir;
        logic        run;
        logic        mr;
        logic [3:0]  st;
        logic [31:0] en;
        logic [31:0] bs;
        logic [3:0]  cs;
        logic        md;
        logic        inc;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(input logic [31:0] ir, input logic run, input logic mr,
                                input logic [3:0] st, input logic [31:0] en,
                                input logic [31:0] bs, input logic [3:0] cs,
                                input logic md, input logic inc);
        vec_t v;
        v.ir = ir; v.run = run; v.mr = mr; v.st = st; v.en = en;
        v.bs = bs; v.cs = cs; v.md = md; v.inc = inc;
        return v;
    endfunction

    task automatic check(input string nm, input vec_t v);
        logic [76:0] act;
        logic [76:0] exp;
        logic        eb;
        eb  = !(v.st == 4'd0 || v.st == 4'd8 || v.st == 4'd9);
        act = {dif.state_dbg, dif.enable, dif.busSelect, dif.Control_Signals,
               dif.MD_Read, dif.IncPC, dif.busy, dif.halted, dif.fault};
        exp = {v.st, v.en, v.bs, v.cs, v.md, v.inc, eb, (v.st == 4'd8), (v.st == 4'd9)};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got st=%0d en=%h bs=%h cs=%0d md=%b inc=%b busy=%b halt=%b flt=%b, expected st=%0d en=%h bs=%h cs=%0d md=%b inc=%b busy=%b halt=%b flt=%b",
                     nm, dif.state_dbg, dif.enable, dif.busSelect, dif.Control_Signals,
                     dif.MD_Read, dif.IncPC, dif.busy, dif.halted, dif.fault,
                     v.st, v.en, v.bs, v.cs, v.md, v.inc, eb, (v.st == 4'd8), (v.st == 4'd9));
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        dif.ir        = v.ir;
        dif.run       = v.run;
        dif.mem_ready = v.mr;
        #1;
        check(nm, v);
    endtask

    task automatic apply_queue(input string nm);
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            apply(v, nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr     = 1'b0;
        dif.run = 1'b0;
        #1;
        check("reset_async", mk(32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        clr = 1'b1;
    endtask

    function automatic logic [3:0] code_of(input logic [4:0] op);
        case (op)
            5'b00011: return 4'd3;
            5'b00100: return 4'd4;
            5'b00101: return 4'd5;
            5'b00110: return 4'd6;
            5'b01111: return 4'd12;
            5'b10000: return 4'd13;
            default:  return 4'd0;
        endcase
    endfunction

    // Expected trace of one instruction straight from the control-step table
    task automatic build_instr(input logic [31:0] ir, input int stall,
                               input logic run_end, input logic rand_run);
        logic [4:0] op;
        logic [3:0] ra, rb, rc, cs;
        logic       alu, mdv, r;
        op  = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        cs  = code_of(op);
        alu = (op == 5'b00011 || op == 5'b00100 || op == 5'b00101 || op == 5'b00110);
        mdv = (op == 5'b01111 || op == 5'b10000);
        r   = rand_run ? 1'($urandom_range(0, 1)) : 1'b1;
        q.push_back(mk(ir, r, 1'($urandom_range(0, 1)), 4'd1, 32'h0210_0000, 32'h0010_0000, 4'd0, 1'b0, 1'b1));
        for (int i = 0; i < stall; i++)
            q.push_back(mk(ir, rand_run ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0,
                           4'd2, 32'h0020_0000, 32'd0, 4'd0, 1'b1, 1'b0));
        q.push_back(mk(ir, r, 1'b1, 4'd2, 32'h0020_0000, 32'd0, 4'd0, 1'b1, 1'b0));
        q.push_back(mk(ir, r, 1'b0, 4'd3, 32'h0100_0000, 32'h0020_0000, 4'd0, 1'b0, 1'b0));
        if (op == 5'b11011) begin
            q.push_back(mk(ir, 1'b1, 1'b1, 4'd4, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
            for (int i = 0; i < 10; i++)
                q.push_back(mk(ir, 1'b1, 1'b1, 4'd8, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
            return;
        end
        if (!alu && !mdv) begin
            q.push_back(mk(ir, 1'b1, 1'b1, 4'd4, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
            for (int i = 0; i < 6; i++)
                q.push_back(mk(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               4'd9, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
            return;
        end
        r = rand_run ? 1'($urandom_range(0, 1)) : run_end;
        q.push_back(mk(ir, r, 1'b0, 4'd4, 32'h0008_0000, 32'd1 << (mdv ? ra : rb), 4'd0, 1'b0, 1'b0));
        q.push_back(mk(ir, r, 1'b0, 4'd5, 32'h0004_0000, 32'd1 << (mdv ? rb : rc), cs, 1'b0, 1'b0));
        if (alu) begin
            q.push_back(mk(ir, run_end, 1'b0, 4'd6, 32'd1 << ra, 32'h0008_0000, 4'd0, 1'b0, 1'b0));
        end else begin
            q.push_back(mk(ir, r, 1'b0, 4'd6, 32'h0002_0000, 32'h0008_0000, 4'd0, 1'b0, 1'b0));
            q.push_back(mk(ir, run_end, 1'b0, 4'd7, 32'h0001_0000, 32'h0004_0000, 4'd0, 1'b0, 1'b0));
        end
        if (!run_end) begin
            q.push_back(mk(ir, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
            q.push_back(mk(ir, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        end
    endtask

    function automatic logic [31:0] rand_ir(input logic [4:0] op);
        return {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 15'($urandom)};
    endfunction

    localparam logic [31:0] C_MUL_IR = 32'h7890_0000;
    localparam logic [31:0] C_ADD_IR = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};

    vec_t       tbl [9];
    logic [4:0] legal_ops [6];
    vec_t       v;

    initial begin
        checks    = 0;
        failures  = 0;
        clr       = 1'b0;
        dif.run       = 1'b0;
        dif.mem_ready = 1'b0;
        dif.ir        = 32'd0;
        legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000};

        tbl[0] = mk(C_MUL_IR, 1, 1, 4'd0, 32'h0000_0000, 32'h0000_0000, 4'd0,  0, 0);
        tbl[1] = mk(C_MUL_IR, 1, 1, 4'd1, 32'h0210_0000, 32'h0010_0000, 4'd0,  0, 1);
        tbl[2] = mk(C_MUL_IR, 1, 1, 4'd2, 32'h0020_0000, 32'h0000_0000, 4'd0,  1, 0);
        tbl[3] = mk(C_MUL_IR, 1, 1, 4'd3, 32'h0100_0000, 32'h0020_0000, 4'd0,  0, 0);
        tbl[4] = mk(C_MUL_IR, 1, 1, 4'd4, 32'h0008_0000, 32'h0000_0002, 4'd0,  0, 0);
        tbl[5] = mk(C_MUL_IR, 1, 1, 4'd5, 32'h0004_0000, 32'h0000_0004, 4'd12, 0, 0);
        tbl[6] = mk(C_MUL_IR, 1, 1, 4'd6, 32'h0002_0000, 32'h0008_0000, 4'd0,  0, 0);
        tbl[7] = mk(C_MUL_IR, 1, 1, 4'd7, 32'h0001_0000, 32'h0004_0000, 4'd0,  0, 0);
        tbl[8] = mk(C_MUL_IR, 0, 0, 4'd1, 32'h0210_0000, 32'h0010_0000, 4'd0,  0, 1);

        #2;
        check("reset_init", mk(32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("mul_tbl[%0d]", i));

        do_reset();
        q.push_back(mk(C_ADD_IR, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        build_instr(C_ADD_IR, 0, 1'b0, 1'b0);
        apply_queue("add_run_drop");

        do_reset();
        q.push_back(mk(32'd0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        build_instr(rand_ir(5'b00100), 3, 1'b1, 1'b0);
        apply_queue("mem_stall");

        do_reset();
        q.push_back(mk(32'd0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        build_instr({5'b11011, 27'd0}, 1, 1'b1, 1'b0);
        apply_queue("halt_sticky");

        do_reset();
        q.push_back(mk(32'd0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        build_instr({5'b11111, 27'h123_4567}, 0, 1'b1, 1'b0);
        apply_queue("fault_sticky");

        // clear pulse in the middle of T4, then restart on the next edge
        do_reset();
        q.push_back(mk(32'd0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        build_instr(C_ADD_IR, 0, 1'b1, 1'b0);
        while (q.size() > 0) begin
            v = q.pop_front();
            apply(v, "clr_mid_t4_pre");
            if (v.st == 4'd5) break;
        end
        q.delete();
        #1 clr = 1'b0;
        #1 check("clr_mid_t4", mk(32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        #1 begin dif.run = 1'b1; clr = 1'b1; end
        @(negedge clk);
        #1 check("clr_restart_t0", mk(32'd0, 1'b1, 1'b0, 4'd1, 32'h0210_0000, 32'h0010_0000, 4'd0, 1'b0, 1'b1));

        do_reset();
        q.push_back(mk(32'd0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0));
        for (int n = 0; n < 40; n++)
            build_instr(rand_ir(legal_ops[$urandom_range(0, 5)]), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b1);
        apply_queue("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Hardwired control unit that drives the Phase 2 datapath through instruction fetch and execute, one control step per clock.
- Replaces hand-timed bench stimulus. It generates the datapath's enable vector, busSelect vector, Control_Signals, MD_Read and IncPC from its state and the IR contents.
- Supports 3-register ALU ops (ADD/SUB/AND/OR), MUL/DIV with HI/LO writeback, HALT, and an illegal-opcode fault.

Parameters:
- OP_ADD, 5'b00011, opcode of ADD
- OP_SUB, 5'b00100, opcode of SUB
- OP_AND, 5'b00101, opcode of AND
- OP_OR, 5'b00110, opcode of OR
- OP_MUL, 5'b01111, opcode of MUL
- OP_DIV, 5'b10000, opcode of DIV
- OP_HALT, 5'b11011, opcode of HALT
- ALU_ADD/SUB/AND/OR/MUL/DIV, 4'd3/4'd4/4'd5/4'd6/4'd12/4'd13, Control_Signals codes

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-low reset
- run  in  1  level; permits starting or continuing instruction execution
- ir  in  32  IR register output from datapath
- mem_ready  in  1  memory has valid data on MDataIn this cycle
- enable  out  32  register load enables: [15:0] R0-R15, 16 HI, 17 LO, 18 Z, 19 Y, 20 PC, 21 MDR, 24 IR, 25 MAR; others 0
- busSelect  out  32  one-hot bus source: [15:0] R0-R15, 16 HI, 17 LO, 18 Zhi, 19 Zlo, 20 PC, 21 MDR; others 0
- Control_Signals  out  4  ALU operation code, 0 when idle
- MD_Read  out  1  MDR takes MDataIn rather than the bus
- IncPC  out  1  PC load takes PC+1
- busy  out  1  high in any state other than IDLE/HALT/FAULT
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- state_dbg  out  4  current state encoding

Behaviour:
- State encodings: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8, FAULT=9. State is registered. All outputs are a Moore decode of state and ir.
- Reset (clr=0): state goes to IDLE immediately. All outputs are 0, including mid-instruction, with no partial enables held.
- IR fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- IDLE: all outputs 0. Go to T0 when run=1.
- T0: busSelect[20], enable[25], enable[20], IncPC=1. Next state is T1.
- T1: MD_Read=1, enable[21]=1. Stay in T1 while mem_ready=0; go to T2 on the first edge with mem_ready=1. The enables stay asserted for every stall cycle.
- T2: busSelect[21], enable[24]. Next state is T3. The ir input is valid from T3 onward.
- T3 decode:
  - op=OP_HALT: no outputs, next state HALT.
  - op not in the supported set: no outputs, next state FAULT.
  - ADD/SUB/AND/OR: busSelect[rb], enable[19].
  - MUL/DIV: busSelect[ra], enable[19].
- T4:
  - ADD/SUB/AND/OR: busSelect[rc], enable[18], Control_Signals=op code.
  - MUL/DIV: busSelect[rb], enable[18], Control_Signals=op code.
- T5: busSelect[19] (Zlo).
  - ADD/SUB/AND/OR: enable[ra]; next state is T0 if run=1, else IDLE.
  - MUL/DIV: enable[17] (LO); next state is T6.
- T6 (MUL/DIV only): busSelect[18], enable[16] (HI). Next state is T0 if run=1, else IDLE.
- Instruction boundaries: run=0 is honoured only at instruction boundaries. An instruction in progress always completes.
- HALT and FAULT are sticky; only clr exits them.
- Output invariants:
  - busSelect is one-hot or zero in every cycle.
  - No enable bit is set outside the map above.
  - Control_Signals is nonzero only in T4.
- Latency (mem_ready tied high): ALU op takes 6 cycles (T0-T5); MUL/DIV takes 7 cycles (T0-T6).
- Every register index 0-15 is legal, including R0 and ra equal to rb.

Test Plan:
- MUL with ir=32'h78900000, run=1, mem_ready=1 -> T3 busSelect=32'h2 enable=32'h80000; T4 busSelect=32'h4 enable=32'h40000 Control_Signals=12; T5 busSelect=32'h80000 enable=32'h20000; T6 busSelect=32'h40000 enable=32'h10000; then T0.
- ADD with ra=3, rb=1, rc=2, run dropped during T4 -> T5 enable=32'h8, busSelect=32'h80000; next state IDLE with all outputs 0.
- mem_ready held low 3 cycles in T1 -> state_dbg=2 for 4 cycles with MD_Read=1 and enable=32'h200000 throughout; T2 follows.
- ir op=OP_HALT -> HALT after T3, halted=1, busy=0; stays in HALT with run=1 for 10 cycles.
- ir op=5'b11111 -> FAULT, fault=1, all outputs 0 thereafter.
- clr pulsed low mid-T4 -> outputs 0 asynchronously; after release with run=1, T0 on the next edge.
